// File: rtl/adder_pkg.sv
// Shared types and default sizes for the adder accumulator slice.
package adder_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational WIDTH-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_accumulator.sv
// Frame accumulator around ripple_carry_adder: sums a beat stream, reports total/overflow/count.
// Define ACC_SATURATE_EN to clamp the accumulator at all-ones after the first carry-out.
module adder_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);

  // Handshake: a beat moves on a rising edge where in_valid & in_ready;
  // a result moves on a rising edge where out_valid & out_ready.

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic               ovf;
  logic [COUNT_W-1:0] count;

  logic               accept;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  assign in_ready  = !rst && (state == ST_IDLE || state == ST_ACCUM);
  assign out_valid = !rst && (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  // The first beat of a frame starts from zero so no stale total leaks in.
  assign add_a = (state == ST_IDLE) ? '0 : acc;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) state_nxt = in_last ? ST_DONE : ST_ACCUM;
      end
      ST_DONE: begin
        if (out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        acc   <= add_sum;
        ovf   <= 1'b0;
        count <= COUNT_W'(1);
      end else begin
        // The counter sticks at all-ones on very long frames.
        if (count != '1) count <= count + COUNT_W'(1);
        ovf <= ovf | add_cout;
`ifdef ACC_SATURATE_EN
        if (ovf || add_cout) acc <= '1;
        else                 acc <= add_sum;
`else
        acc <= add_sum;
`endif
      end
    end
  end

  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomized and directed bench for adder_accumulator, checked against a frame-level arithmetic model.
module tb_adder_accumulator;
  import adder_pkg::*;

  localparam int WIDTH   = 4;
  localparam int COUNT_W = 8;
  localparam int RW      = WIDTH + 1 + COUNT_W;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic               out_ovf;
  logic [COUNT_W-1:0] out_count;

  adder_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 2;  // 0 random, 1 hold low, 2 always high

  // ---------------- model / scoreboard ----------------
  int mdl_total = 0;
  int mdl_n     = 0;
  logic [RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] model_result(input int total, input int n);
    int   s;
    int   c;
    logic o;
    o = (total >= (1 << WIDTH));
`ifdef ACC_SATURATE_EN
    s = o ? (1 << WIDTH) - 1 : total;
`else
    s = total % (1 << WIDTH);
`endif
    c = (n > (1 << COUNT_W) - 1) ? (1 << COUNT_W) - 1 : n;
    return {s[WIDTH-1:0], o, c[COUNT_W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) fail_now("beat_accept");
    else begin
      mdl_total += int'(d);
      mdl_n++;
      if (last) begin
        exp_q.push_back(model_result(mdl_total, mdl_n));
        mdl_total = 0;
        mdl_n     = 0;
      end
    end
  endtask

  // Called right after the last beat is accepted: result must be up one cycle later.
  task automatic check_done(input int s, input int o, input int c);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("lit_sum", out_sum, s);
    check("lit_ovf", out_ovf, o);
    check("lit_count", out_count, c);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      idle = !out_valid;
    end
    if (!idle) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mdl_total = 0;
    mdl_n     = 0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_sum", out_sum, 0);
    check("post_rst_ovf", out_ovf, 0);
    check("post_rst_count", out_count, 0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic          hold_prev = 1'b0;
  logic [RW-1:0] prev_res  = '0;

  always @(negedge clk) begin
    if (rst) hold_prev = 1'b0;
    else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", {out_sum, out_ovf, out_count}, prev_res);
      end
      if (out_valid) begin
        check("in_ready_in_done", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result: unexpected result %0d/%0d/%0d (t=%0t)",
                     out_sum, out_ovf, out_count, $time);
          end else begin
            check("result", {out_sum, out_ovf, out_count}, exp_q.pop_front());
          end
        end
        hold_prev = !out_ready;
        prev_res  = {out_sum, out_ovf, out_count};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    @(negedge clk);
    check("init_in_ready", in_ready, 0);
    check("init_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_sum", out_sum, 0);
    check("init_count", out_count, 0);
    @(posedge clk);
    #1;

    // Plain three-beat frame.
    send_beat(4'd3, 1'b0);
    send_beat(4'd5, 1'b0);
    send_beat(4'd6, 1'b1);
    check_done(14, 0, 3);

    // Carry-out in the frame.
    send_beat(4'd9, 1'b0);
    send_beat(4'd8, 1'b1);
`ifdef ACC_SATURATE_EN
    check_done(15, 1, 2);
`else
    check_done(1, 1, 2);
`endif

    // Single-beat frame.
    send_beat(4'd7, 1'b1);
    check_done(7, 0, 1);

    // Consumer stalls for 5 cycles while new beats are offered.
    wait_idle();
    ready_mode = 1;
    send_beat(4'd7, 1'b1);
    check_done(7, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 4'd9;
      in_last  = 1'b1;
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum", out_sum, 7);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    ready_mode = 2;
    wait_idle();
    send_beat(4'd2, 1'b0);
    send_beat(4'd2, 1'b1);
    check_done(4, 0, 2);

    // Reset mid-frame leaves no residue.
    wait_idle();
    send_beat(4'd4, 1'b0);
    send_beat(4'd4, 1'b0);
    do_reset();
    send_beat(4'd1, 1'b1);
    check_done(1, 0, 1);

    // Reset while a result is pending.
    wait_idle();
    ready_mode = 1;
    send_beat(4'd5, 1'b1);
    check_done(5, 0, 1);
    do_reset();
    ready_mode = 2;

    // Gaps of two idle cycles between beats.
    send_beat(4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send_beat(4'd1, 1'b1);
    check_done(3, 0, 3);

    // Beat counter saturates instead of wrapping.
    for (int i = 0; i < 299; i++) send_beat(4'd0, 1'b0);
    send_beat(4'd0, 1'b1);
    check_done(0, 0, 255);

    // Random frames, random gaps, random consumer backpressure.
    ready_mode = 0;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        send_beat(WIDTH'($urandom_range(0, 15)), b == n - 1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    ready_mode = 2;
    wait_idle();
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
